uart_rx_frame_buffer: RTL and testbench
=======================================

Name: uart_rx_frame_buffer

Overview:
Receive-side controller between the UART RX frame checker and the system consumer. It buffers each frame the RX FSM qualifies with Data_Valid in a small show-ahead FIFO and presents the frames to the consumer on a valid/ready handshake. It also keeps saturating counters for parity errors, stop errors and overruns, plus a sticky overrun flag, so that software can monitor link quality.

Parameters:
DATA_WIDTH, 8, width of one received data word.
DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.
CNT_WIDTH, 8, width of each saturating error/overrun counter.

Ports:
CLK  input  1  receive-domain clock; same clock as the RX FSM.
RST  input  1  asynchronous active-low reset.
P_DATA  input  DATA_WIDTH  deserialized frame data; valid only while Data_Valid=1.
Data_Valid  input  1  single-cycle pulse marking a good frame.
par_err  input  1  single-cycle pulse for a frame discarded on parity error.
stp_err  input  1  single-cycle pulse for a frame discarded on stop error.
out_ready  input  1  consumer accepts the word on out_data this cycle.
clr_stat  input  1  synchronous clear of all counters and the overrun flag.
out_data  output  DATA_WIDTH  oldest buffered word (show-ahead).
out_valid  output  1  buffer is non-empty.
full  output  1  buffer holds DEPTH words.
level  output  log2(DEPTH)+1  number of words buffered, 0..DEPTH.
overrun  output  1  sticky flag: a good frame was dropped because the buffer was full.
par_err_cnt  output  CNT_WIDTH  saturating count of parity-error frames.
stp_err_cnt  output  CNT_WIDTH  saturating count of stop-error frames.
ovr_cnt  output  CNT_WIDTH  saturating count of dropped good frames.

Behaviour:
- Reset (RST=0, asynchronous) clears the following: all outputs, read/write pointers, state EMPTY, counters and the overrun flag. out_data reads 0. Storage contents are don't-care.
- A reset asserted mid-operation discards all buffered words immediately. No partial frame is retained.
- The block has three states, decoded from level:
  - EMPTY: level=0, out_valid=0, full=0.
  - PARTIAL: 0<level<DEPTH.
  - FULL: level=DEPTH, full=1.
- A push is accepted when Data_Valid=1 and the buffer is not full, or when it is full and a pop happens in the same cycle.
- A pop happens when out_valid=1 and out_ready=1. out_ready is ignored while out_valid=0.
- Latency: a word pushed in cycle N appears on out_data with out_valid=1 in cycle N+1 when the buffer was empty. Pushing into an empty buffer never bypasses the register stage in the same cycle.
- out_data always shows the entry at the read pointer. It stays stable while out_valid=1 and no pop occurs.
- Simultaneous push and pop in PARTIAL or FULL leaves level unchanged and advances both pointers. The same pair in EMPTY performs the push only.
- Pointers wrap modulo DEPTH. level is a separate counter, or is derived from pointers carrying an extra wrap bit; it must never exceed DEPTH.
- Drop rule: Data_Valid=1 while full=1 with no pop discards P_DATA and leaves the contents untouched. overrun is set to 1 and ovr_cnt increments.
- par_err and stp_err pulses increment their own counters. Both may assert in the same cycle, and each counter then increments once. Neither pulse touches the FIFO.
- All counters saturate at 2^CNT_WIDTH-1 and never wrap.
- clr_stat=1 zeroes all three counters and overrun in the next cycle. If an increment event occurs in the same cycle, the clear wins and the counter reads 0.
- clr_stat does not affect buffered data, pointers or level.
- Data_Valid and an error pulse in the same cycle are processed independently. This case cannot occur with a legal RX FSM, but it must be handled.

Test Plan:
- Reset, then push 0xA5 in cycle N with out_ready=0. Required: out_valid=1, out_data=0xA5 and level=1 from cycle N+1. Hold 3 cycles, data stable. Pulse out_ready and level returns to 0.
- Push 0x01..0x04 with DEPTH=4 and no reads, then push 0x05. Required: full=1, level=4, 0x05 dropped, overrun=1, ovr_cnt=1. Reads return 0x01,0x02,0x03,0x04 in order.
- Reach FULL, then assert Data_Valid=0x66 together with out_ready=1. Required: pop of the oldest word and push accepted, level stays 4, overrun stays 0. 0x66 is read last.
- Run 6 push/pop cycles wrapping the pointers twice. Required: FIFO order preserved across the wrap, level never exceeds 4, EMPTY is reached after the last pop.
- Apply 300 par_err pulses with CNT_WIDTH=8. Required: par_err_cnt saturates at 255. Then assert clr_stat together with a stp_err pulse: required result is stp_err_cnt=0 and par_err_cnt=0.
- Assert RST low with 3 words buffered and overrun=1. Required: out_valid=0, level=0, overrun=0 and all counters 0 immediately. After release, the first push is read back correctly.

Source files
------------

// File: rtl/uart_rx_frame_buffer_if.sv
// Handshake bundle between the UART RX frame checker, the frame buffer and
// the downstream consumer. The master side drives received frames and the
// consumer ready; the slave side (the buffer) returns the show-ahead word.
interface uart_rx_frame_buffer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;

  modport master (
    output P_DATA, Data_Valid, par_err, stp_err, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  P_DATA, Data_Valid, par_err, stp_err, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/uart_rx_frame_buffer.sv
// Receive-side frame buffer: a small show-ahead FIFO between the UART RX
// frame checker and the consumer, plus saturating link-quality counters
// (parity errors, stop errors, dropped frames) and a sticky overrun flag.
module uart_rx_frame_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  uart_rx_frame_buffer_if.slave    bus,
  input  logic                     clr_stat,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun,
  output logic [CNT_WIDTH-1:0]     par_err_cnt,
  output logic [CNT_WIDTH-1:0]     stp_err_cnt,
  output logic [CNT_WIDTH-1:0]     ovr_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         rd_ptr_nxt;
  logic [LW-1:0]         level_nxt;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Flags are decoded from the registered state, so they carry no
  // combinational path from the inputs.
  assign full          = (state == FULL);
  assign bus.out_valid = (state != EMPTY);

  // Handshake decode, next level and the word that will sit at the head
  // after this edge (the incoming word when it lands in the head slot).
  always_comb begin
    pop        = bus.out_valid & bus.out_ready;
    push       = bus.Data_Valid & (~full | pop);
    drop       = bus.Data_Valid & full & ~pop;
    rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
    level_nxt  = level;
    if (push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (pop && !push) begin
      level_nxt = level - LW'(1);
    end
    if (push && (wr_ptr == rd_ptr_nxt)) begin
      head_nxt = bus.P_DATA;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Storage array; contents are don't-care after reset, so no reset here.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= bus.P_DATA;
    end
  end

  // Buffer FSM: pointers, level, state and the registered head word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= EMPTY;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      bus.out_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr       <= rd_ptr_nxt;
      level        <= level_nxt;
      bus.out_data <= head_nxt;
      if (level_nxt == '0) begin
        state <= EMPTY;
      end else if (level_nxt == LW'(DEPTH)) begin
        state <= FULL;
      end else begin
        state <= PARTIAL;
      end
    end
  end

  // Link-quality statistics: saturating counters and sticky overrun,
  // with a same-cycle clear taking priority over any increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
      ovr_cnt     <= '0;
      overrun     <= 1'b0;
    end else if (clr_stat) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
      ovr_cnt     <= '0;
      overrun     <= 1'b0;
    end else begin
      if (bus.par_err && (par_err_cnt != '1)) begin
        par_err_cnt <= par_err_cnt + CNT_WIDTH'(1);
      end
      if (bus.stp_err && (stp_err_cnt != '1)) begin
        stp_err_cnt <= stp_err_cnt + CNT_WIDTH'(1);
      end
      if (drop) begin
        overrun <= 1'b1;
        if (ovr_cnt != '1) begin
          ovr_cnt <= ovr_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_buffer.sv
// Testbench for uart_rx_frame_buffer: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_uart_rx_frame_buffer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          clr_stat = 1'b0;
  logic          full;
  logic [LW-1:0] level;
  logic          overrun;
  logic [CW-1:0] par_err_cnt;
  logic [CW-1:0] stp_err_cnt;
  logic [CW-1:0] ovr_cnt;

  uart_rx_frame_buffer_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_frame_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus),
    .clr_stat(clr_stat),
    .full(full),
    .level(level),
    .overrun(overrun),
    .par_err_cnt(par_err_cnt),
    .stp_err_cnt(stp_err_cnt),
    .ovr_cnt(ovr_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference model: the queue holds the expected buffer contents in order
  // and doubles as the scoreboard the monitor pops from.
  logic [DW-1:0] sb[$];
  int            exp_par;
  int            exp_stp;
  int            exp_ovr;
  int            exp_overrun;
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every observable output against the model's current state.
  task automatic checkState();
    checkOutput("level", int'(level), sb.size());
    checkOutput("out_valid", int'(bus.out_valid), (sb.size() > 0) ? 1 : 0);
    checkOutput("full", int'(full), (sb.size() == DEPTH) ? 1 : 0);
    checkOutput("overrun", int'(overrun), exp_overrun);
    checkOutput("par_err_cnt", int'(par_err_cnt), exp_par);
    checkOutput("stp_err_cnt", int'(stp_err_cnt), exp_stp);
    checkOutput("ovr_cnt", int'(ovr_cnt), exp_ovr);
    if (sb.size() > 0) begin
      checkOutput("out_data_head", int'(bus.out_data), int'(sb[0]));
    end
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge,
  // then check the outputs just after that edge.
  task automatic applyStimulus(input bit dv, input logic [DW-1:0] data, input bit rdy,
                               input bit pe, input bit se, input bit clr);
    int lvl;
    bit pop_m;
    bit dropped;
    bus.Data_Valid = dv;
    bus.P_DATA     = data;
    bus.out_ready  = rdy;
    bus.par_err    = pe;
    bus.stp_err    = se;
    clr_stat       = clr;
    lvl     = sb.size();
    pop_m   = (lvl > 0) && rdy;
    dropped = dv && (lvl == DEPTH) && !pop_m;
    if (dv && !dropped) sb.push_back(data);
    if (clr) begin
      exp_par = 0;
      exp_stp = 0;
      exp_ovr = 0;
      exp_overrun = 0;
    end else begin
      if (pe) exp_par = (exp_par < CMAX) ? exp_par + 1 : CMAX;
      if (se) exp_stp = (exp_stp < CMAX) ? exp_stp + 1 : CMAX;
      if (dropped) begin
        exp_overrun = 1;
        exp_ovr = (exp_ovr < CMAX) ? exp_ovr + 1 : CMAX;
      end
    end
    @(posedge CLK);
    #1;
    checkState();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic clearModel();
    sb.delete();
    exp_par = 0;
    exp_stp = 0;
    exp_ovr = 0;
    exp_overrun = 0;
  endtask

  // Assert reset away from the clock edge and check the asynchronous clear.
  task automatic doReset();
    bus.Data_Valid = 0;
    bus.P_DATA     = '0;
    bus.out_ready  = 0;
    bus.par_err    = 0;
    bus.stp_err    = 0;
    clr_stat       = 0;
    RST = 1'b0;
    #1;
    clearModel();
    checkState();
    checkOutput("reset_out_data", int'(bus.out_data), 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    checkState();
  endtask

  // Monitor: whenever the consumer handshake completes, the presented word
  // must match the oldest entry of the scoreboard.
  always @(negedge CLK) begin
    logic [DW-1:0] expv;
    if (RST && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("pop_unexpected", 1, 0);
      end else begin
        expv = sb.pop_front();
        checkOutput("pop_data", int'(bus.out_data), int'(expv));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearModel();
    bus.Data_Valid = 0;
    bus.P_DATA     = '0;
    bus.out_ready  = 0;
    bus.par_err    = 0;
    bus.stp_err    = 0;
    #2;
    checkState();
    checkOutput("reset_out_data", int'(bus.out_data), 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // Single word into an empty buffer, held, then popped.
    applyStimulus(1, 8'hA5, 0, 0, 0, 0);
    checkOutput("first_word", int'(bus.out_data), 8'hA5);
    idle(3);
    checkOutput("held_word", int'(bus.out_data), 8'hA5);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    idle(1);

    // Fill to FULL, then a dropped frame, then drain in order.
    for (int i = 1; i <= 5; i++) applyStimulus(1, 8'(i), 0, 0, 0, 0);
    checkOutput("overrun_set", int'(overrun), 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0, 0, 0);
    idle(1);

    // FULL with simultaneous push and pop keeps the level and no overrun.
    applyStimulus(0, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'h10 + 8'(i), 0, 0, 0, 0);
    applyStimulus(1, 8'h66, 1, 0, 0, 0);
    checkOutput("full_pushpop_level", int'(level), 4);
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0, 0, 0);
    idle(1);

    // Streaming push/pop so the pointers wrap twice, then drain.
    applyStimulus(1, 8'h40, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) applyStimulus(1, 8'h40 + 8'(i), 1, 0, 0, 0);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    idle(1);

    // Parity counter saturation, then clear colliding with a stop error.
    for (int i = 0; i < 300; i++) applyStimulus(0, 8'h00, 0, 1, 0, 0);
    checkOutput("par_saturated", int'(par_err_cnt), 255);
    applyStimulus(0, 8'h00, 0, 0, 1, 1);

    // Three words buffered with overrun set, then a mid-operation reset.
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'h21 + 8'(i), 0, 1, 1, 0);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    doReset();
    applyStimulus(1, 8'h3C, 0, 0, 0, 0);
    applyStimulus(0, 8'h00, 1, 0, 0, 0);
    idle(1);

    // Randomized traffic with a slow and then a fast consumer.
    for (int i = 0; i < 3000; i++) begin
      bit dv;
      bit rdy;
      dv  = ($urandom_range(0, 2) != 0);
      rdy = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      applyStimulus(dv, 8'($urandom), rdy,
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 8'h00, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
